// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: bus word, RAM handshake state and latency-RAM FSM state.
// Imported by the latency RAM, its counter, its interface and the bench.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic {
        IDLE,
        WAIT
    } lat_ram_state_t;

    localparam int RAM_LAT_DEFAULT = 2;
    localparam int RAM_CNT_W       = 4;

    // Counter reload value for a given latency (LAT-1 wait cycles remain
    // after the cycle that latches the request).
    function automatic logic [RAM_CNT_W-1:0] lat_reload(input int lat);
        return RAM_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/lat_ram_if.sv
// CPU/RAM request bus: level-held REN/WEN, address, store data; RAM answers
// with ramstate and ramload. master = initiator, slave = RAM.
interface lat_ram_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN,
        output ramWEN,
        output ramaddr,
        output ramstore,
        input  ramload,
        input  ramstate
    );

    modport slave (
        input  ramREN,
        input  ramWEN,
        input  ramaddr,
        input  ramstore,
        output ramload,
        output ramstate
    );

endinterface

// File: rtl/ram_lat_ctr.sv
// Loadable wait-state down-counter; load sets LAT-1, decrement stops at 0.
// Ports: CLK, nRST, i_load, i_dec in; o_value, o_zero out.
module ram_lat_ctr
    import cpu_types_pkg::*;
#(
    parameter int LAT = RAM_LAT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 i_load,
    input  logic                 i_dec,
    output logic [RAM_CNT_W-1:0] o_value,
    output logic                 o_zero
);

    logic [RAM_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= lat_reload(LAT);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/lat_ram.sv
// Latency-modelled word RAM: LAT BUSY cycles then one ACCESS cycle per request.
// Ports: CLK, nRST scalars; ram (lat_ram_if.slave) carries the request bus.
module lat_ram
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = 4096
) (
    input  logic        CLK,
    input  logic        nRST,
    lat_ram_if.slave    ram
);

    localparam int AW = $clog2(DEPTH);

    logic                 w_ren;
    logic                 w_wen;
    logic [29:0]          w_waddr;
    logic                 w_any;
    logic                 w_valid;
    logic                 w_same;
    logic                 w_hit;
    logic                 w_access;
    logic                 w_load;
    logic                 w_dec;
    logic                 w_zero;
    logic [RAM_CNT_W-1:0] w_cnt;
    logic                 w_unused;

    lat_ram_state_t       r_state;
    logic                 r_op;
    logic [AW-1:0]        r_addr;

    // Contents survive reset; zero only at power-up.
    word_t                r_mem [DEPTH] = '{default: '0};

    assign w_ren    = ram.ramREN;
    assign w_wen    = ram.ramWEN;
    assign w_waddr  = ram.ramaddr[31:2];
    assign w_any    = w_ren | w_wen;
    assign w_valid  = (w_ren ^ w_wen)
                   && ({2'b00, w_waddr} < 32'(DEPTH));

    // Live request matches the latched one (valid implies upper bits zero).
    assign w_same   = w_valid
                   && (w_wen == r_op)
                   && (w_waddr == 30'(r_addr));

    assign w_hit    = (r_state == WAIT) && w_same;
    assign w_access = w_hit && w_zero;
    assign w_dec    = w_hit && !w_zero;

    // New transaction from IDLE, or restart after a changed request.
    assign w_load   = w_valid && !w_hit;

    assign w_unused = ^{ram.ramaddr[1:0], w_cnt};

    ram_lat_ctr #(
        .LAT     (LAT)
    ) u_ctr (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .o_value (w_cnt),
        .o_zero  (w_zero)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_op    <= 1'b0;
            r_addr  <= '0;
        end else begin
            if (w_load) begin
                r_op   <= w_wen;
                r_addr <= w_waddr[AW-1:0];
            end
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Stay only while counting down or restarting.
                    if (w_access || !w_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write commits at the edge closing the ACCESS cycle; an aborted
    // or reset transaction never reaches ACCESS.
    always_ff @(posedge CLK) begin
        if (w_access && r_op) begin
            r_mem[r_addr] <= ram.ramstore;
        end
    end

    always_comb begin
        ram.ramstate = FREE;
        ram.ramload  = '0;
        if (w_access) begin
            ram.ramstate = ACCESS;
            if (!r_op) begin
                ram.ramload = r_mem[r_addr];
            end
        end else if (w_valid) begin
            ram.ramstate = BUSY;
        end else if (w_any) begin
            ram.ramstate = ERROR;
        end
    end

endmodule

// File: tb/tb_lat_ram.sv
// Scoreboard bench for lat_ram: LAT=2 and LAT=1 instances share one stimulus
// stream; a transaction-level model predicts ramstate/ramload per cycle.
module tb_lat_ram;
    import cpu_types_pkg::*;

    localparam int DEPTH = 4096;

    typedef struct packed {
        ramstate_t st;
        word_t     ld;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    lat_ram_if if2 ();
    lat_ram_if if1 ();

    lat_ram #(.LAT(2), .DEPTH(DEPTH)) u_dut2 (
        .CLK  (clk),
        .nRST (nrst),
        .ram  (if2.slave)
    );

    lat_ram #(.LAT(1), .DEPTH(DEPTH)) u_dut1 (
        .CLK  (clk),
        .nRST (nrst),
        .ram  (if1.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t        q [2][$];
    bit          m_have [2];
    bit          m_op   [2];
    int unsigned m_addr [2];
    int          m_age  [2];
    bit [31:0]   m_mem  [2][DEPTH];
    int          lat_of [2] = '{2, 1};

    // Transaction view: a request is served LAT cycles after it first
    // appears unchanged; anything else restarts, frees or errors.
    function automatic exp_t model(input int k, input bit r, input bit w,
                                   input word_t a, input word_t d,
                                   input bit rp);
        exp_t        e;
        int unsigned wa;
        bit          ok;
        e.st = FREE;
        e.ld = '0;
        wa   = {2'b00, a[31:2]};
        ok   = (r ^ w) && (wa < 32'(DEPTH));
        if (rp) m_have[k] = 1'b0;
        if (m_have[k] && ok && (w == m_op[k]) && (wa == m_addr[k])) begin
            m_age[k]++;
            if (m_age[k] == lat_of[k]) begin
                e.st      = ACCESS;
                m_have[k] = 1'b0;
                if (w) m_mem[k][wa] = d;
                else   e.ld = m_mem[k][wa];
            end else begin
                e.st = BUSY;
            end
        end else begin
            m_have[k] = 1'b0;
            if (ok) begin
                m_have[k] = 1'b1;
                m_op[k]   = w;
                m_addr[k] = wa;
                m_age[k]  = 0;
                e.st      = BUSY;
            end else if (r | w) begin
                e.st = ERROR;
            end
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit w, input word_t a,
                        input word_t d, input bit rp);
        @(posedge clk);
        #1;
        if2.ramREN = r;  if2.ramWEN = w;
        if2.ramaddr = a; if2.ramstore = d;
        if1.ramREN = r;  if1.ramWEN = w;
        if1.ramaddr = a; if1.ramstore = d;
        if (rp) nrst = 1'b0;
        for (int k = 0; k < 2; k++) q[k].push_back(model(k, r, w, a, d, rp));
        if (rp) begin
            #2;
            nrst = 1'b1;
        end
        cyc++;
    endtask

    task automatic hold(input bit r, input bit w, input word_t a,
                        input word_t d, input int n);
        for (int i = 0; i < n; i++) step(r, w, a, d, 1'b0);
    endtask

    // Monitor: the DUT answers every cycle, so each negedge pops one entry.
    initial begin
        exp_t      e;
        ramstate_t ast [2];
        word_t     ald [2];
        string     nm;
        forever begin
            @(negedge clk);
            ast[0] = if2.ramstate; ald[0] = if2.ramload;
            ast[1] = if1.ramstate; ald[1] = if1.ramload;
            for (int k = 0; k < 2; k++) begin
                if (q[k].size() > 0) begin
                    e  = q[k].pop_front();
                    nm = (k == 0) ? "lat2" : "lat1";
                    checks++;
                    if (ast[k] !== e.st) begin
                        errors++;
                        $display("FAIL %s_state t=%0t got %s want %s",
                                 nm, $time, ast[k].name(), e.st.name());
                    end
                    checks++;
                    if (ald[k] !== e.ld) begin
                        errors++;
                        $display("FAIL %s_load t=%0t got %h want %h",
                                 nm, $time, ald[k], e.ld);
                    end
                end
            end
        end
    end

    initial begin
        bit    cr, cw, rp;
        word_t ca, cd;
        int    p;

        if2.ramREN = 1'b0; if2.ramWEN = 1'b0;
        if2.ramaddr = '0;  if2.ramstore = '0;
        if1.ramREN = 1'b0; if1.ramWEN = 1'b0;
        if1.ramaddr = '0;  if1.ramstore = '0;

        // Reset state.
        step(0, 0, 32'h0, 32'h0, 1'b1);
        step(0, 0, 32'h0, 32'h0, 1'b0);

        // Read after reset.
        hold(1, 0, 32'h40, 32'h0, 3);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Write then read, plus byte-offset alias.
        hold(0, 1, 32'h100, 32'hDEADBEEF, 3);
        hold(0, 0, 32'h0, 32'h0, 1);
        hold(1, 0, 32'h100, 32'h0, 3);
        hold(1, 0, 32'h102, 32'h0, 3);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Mid-transaction address change.
        hold(0, 1, 32'h20, 32'hA5A5_0020, 3);
        hold(0, 0, 32'h0, 32'h0, 1);
        hold(1, 0, 32'h10, 32'h0, 1);
        hold(1, 0, 32'h20, 32'h0, 3);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Protocol errors and out-of-range writes.
        hold(1, 1, 32'h100, 32'h1111_1111, 1);
        hold(1, 0, 32'h4000, 32'h0, 1);
        hold(0, 1, 32'h4000, 32'h2222_2222, 3);
        hold(0, 0, 32'h0, 32'h0, 1);
        hold(1, 0, 32'h100, 32'h0, 3);
        hold(1, 0, 32'h0, 32'h0, 3);
        hold(0, 1, 32'h3FFC, 32'h0BAD_F00D, 3);
        hold(1, 0, 32'h3FFC, 32'h0, 3);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Reset during write.
        hold(0, 1, 32'h80, 32'h12345678, 1);
        step(0, 0, 32'h0, 32'h0, 1'b1);
        hold(1, 0, 32'h80, 32'h0, 3);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Back-to-back held read.
        hold(1, 0, 32'h0, 32'h0, 4);
        hold(0, 0, 32'h0, 32'h0, 1);

        // Randomised traffic.
        cr = 0; cw = 0; ca = '0; cd = '0;
        for (int i = 0; i < 3000; i++) begin
            rp = ($urandom_range(99) == 0);
            if (rp) begin
                cr = 0; cw = 0;
            end else if ($urandom_range(99) >= 75) begin
                p  = int'($urandom_range(99));
                cd = $urandom;
                if (p < 10) begin
                    cr = 0; cw = 0;
                end else if (p < 16) begin
                    cr = 1; cw = 1;
                    ca = $urandom_range(31) << 2;
                end else if (p < 22) begin
                    cr = $urandom_range(1) == 1; cw = !cr;
                    ca = 32'h4000 | ($urandom & 32'hFFFF_FFFF);
                end else if (p < 27) begin
                    cr = $urandom_range(1) == 1; cw = !cr;
                    ca = 32'h3FFC | $urandom_range(3);
                end else begin
                    cr = $urandom_range(1) == 1; cw = !cr;
                    ca = ($urandom_range(31) << 2) | $urandom_range(3);
                end
            end
            step(cr, cw, ca, cd, rp);
        end
        hold(0, 0, 32'h0, 32'h0, 1);

        @(negedge clk);
        #1;
        checks++;
        if ((q[0].size() + q[1].size()) != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0",
                     q[0].size() + q[1].size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
